// File: rtl/mem_wait_sram.sv
// Single-port 32-bit word SRAM with a programmable number of busy (wait) cycles per access.
// Optional out-of-range flag s_err is enabled by defining SRAM_ERR_EN.
module mem_wait_sram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_cs,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [3:0]  s_byte,
  input  logic [31:0] s_di,
  output logic [31:0] s_do,
  output logic        s_busy
`ifdef SRAM_ERR_EN
  ,
  output logic        s_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_busy;
  logic [31:0]     r_do;
  logic            r_err;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_byte;
  logic [31:0]     r_di;
  logic            r_oor;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_perform;
  logic            w_p_we;
  logic [AW-1:0]   w_p_idx;
  logic [3:0]      w_p_byte;
  logic [31:0]     w_p_di;
  logic            w_p_oor;
  logic [31:0]     w_rd_data;

  assign w_accept = s_cs & ~r_busy;
  assign w_idx    = s_addr[AW+1:2];

`ifdef SRAM_ERR_EN
  assign w_oor = (s_addr[31:2] >= 30'(DEPTH));
  assign s_err = r_err;
  wire w_unused = ^s_addr[1:0];
`else
  assign w_oor = 1'b0;
  wire w_unused = ^{s_addr[31:AW+2], s_addr[1:0], r_err};
`endif

  // With no wait states the access happens on the accept edge straight from the inputs;
  // otherwise it is replayed from the pending register when the counter expires.
  assign w_perform = (WAIT_CYCLES == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 8'd0));
  assign w_p_we    = (r_state == S_IDLE) ? s_we   : r_we;
  assign w_p_idx   = (r_state == S_IDLE) ? w_idx  : r_idx;
  assign w_p_byte  = (r_state == S_IDLE) ? s_byte : r_byte;
  assign w_p_di    = (r_state == S_IDLE) ? s_di   : r_di;
  assign w_p_oor   = (r_state == S_IDLE) ? w_oor  : r_oor;
  assign w_rd_data = w_p_oor ? 32'h0 : r_mem[w_p_idx];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_do    <= 32'h0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_byte  <= 4'h0;
      r_di    <= 32'h0;
      r_oor   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_perform) begin
        if (!w_p_we) r_do <= w_rd_data;
        r_err <= w_p_oor;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= s_we;
            r_idx  <= w_idx;
            r_byte <= s_byte;
            r_di   <= s_di;
            r_oor  <= w_oor;
            if (WAIT_CYCLES != 0) begin
              r_cnt   <= 8'(WAIT_CYCLES - 1);
              r_busy  <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array is deliberately not reset; aresetn gating keeps a write out of a reset edge.
  always_ff @(posedge aclk) begin
    if (aresetn && w_perform && w_p_we && !w_p_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_p_byte[i]) r_mem[w_p_idx][8*i +: 8] <= w_p_di[8*i +: 8];
      end
    end
  end

  assign s_do   = r_do;
  assign s_busy = r_busy;

endmodule
